seg_p2s_drv: RTL and testbench

- Downstream consumer of the 4-digit counter value (and wider hex words) produced by the top-level register/add-sub datapath.
- Encodes eight hex nibbles into seven-segment patterns, applies per-digit blanking and decimal points, then shifts the resulting 64-bit frame serially into the board's external segment shift-register chain and latches it.
- Sits beside the LED serial driver, replacing direct AN/SEGMENT scanning for the 8-digit serial display.

---
 rtl/seg_p2s_drv.sv | 136 +++++++++++++
 tb/tb_seg_p2s_drv.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seg_p2s_drv.sv
// Eight-digit hex to seven-segment encoder feeding an external serial segment
// shift-register chain: 64 bits MSB first, then a latch strobe.
module seg_p2s_drv #(
  parameter int DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] hexs,
  input  logic [7:0]  les,
  input  logic [7:0]  points,
  output logic        busy,
  output logic        done,
  output logic        SEG_CLK,
  output logic        SEG_DT,
  output logic        SEG_PEN,
  output logic        SEG_CLR_n
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t            state_reg, state_next;
  logic [63:0]       frame_next;
  logic [63:0]       shadow_reg;
  logic [5:0]        bit_cnt_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic              busy_reg, done_reg;
  logic              seg_clk_reg, seg_dt_reg, seg_pen_reg, seg_clr_n_reg;
  logic              half_done, last_bit;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Segments are active-low; a blanked digit is all ones including dp.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      assign frame_next[8*gi +: 8] = les[gi] ? 8'hFF
                                   : {~points[gi], ~hex_to_seg(hexs[4*gi +: 4])};
    end
  endgenerate

  assign half_done = (div_cnt_reg == DIV_W'(DIV - 1));
  assign last_bit  = (bit_cnt_reg == 6'd63);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (half_done && seg_clk_reg && last_bit) state_next = LATCH;
      LATCH:   if (half_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // SEG_CLK doubles as the half-bit phase: low half first, high half second.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shadow_reg    <= '0;
      bit_cnt_reg   <= '0;
      div_cnt_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      seg_clk_reg   <= 1'b0;
      seg_dt_reg    <= 1'b0;
      seg_pen_reg   <= 1'b0;
      seg_clr_n_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      done_reg      <= 1'b0;
      seg_clr_n_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (start) begin
            // First bit goes straight to the pin; the shadow holds the rest.
            shadow_reg  <= {frame_next[62:0], 1'b0};
            seg_dt_reg  <= frame_next[63];
            busy_reg    <= 1'b1;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
            seg_clk_reg <= 1'b0;
          end
        end
        SHIFT: begin
          if (half_done) begin
            div_cnt_reg <= '0;
            if (!seg_clk_reg) begin
              seg_clk_reg <= 1'b1;
            end else begin
              seg_clk_reg <= 1'b0;
              if (last_bit) begin
                seg_dt_reg  <= 1'b0;
                seg_pen_reg <= 1'b1;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 6'd1;
                seg_dt_reg  <= shadow_reg[63];
                shadow_reg  <= {shadow_reg[62:0], 1'b0};
              end
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end
        LATCH: begin
          if (half_done) begin
            div_cnt_reg <= '0;
            seg_pen_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign SEG_CLK   = seg_clk_reg;
  assign SEG_DT    = seg_dt_reg;
  assign SEG_PEN   = seg_pen_reg;
  assign SEG_CLR_n = seg_clr_n_reg;

endmodule

// File: tb/tb_seg_p2s_drv.sv
// Directed bench for seg_p2s_drv: one DIV=2 instance for frame/timing checks,
// one DIV=1 instance for back-to-back frames.
module tb_seg_p2s_drv;

  localparam int D0 = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [31:0] hexs = '0;
  logic [7:0]  les = '0;
  logic [7:0]  points = '0;

  logic busy0, done0, sclk0, sdt0, spen0, sclr0;
  logic busy1, done1, sclk1, sdt1, spen1, sclr1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  seg_p2s_drv #(.DIV(D0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .hexs(hexs), .les(les), .points(points),
    .busy(busy0), .done(done0), .SEG_CLK(sclk0), .SEG_DT(sdt0),
    .SEG_PEN(spen0), .SEG_CLR_n(sclr0)
  );

  seg_p2s_drv #(.DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .hexs(hexs), .les(les), .points(points),
    .busy(busy1), .done(done1), .SEG_CLK(sclk1), .SEG_DT(sdt1),
    .SEG_PEN(spen1), .SEG_CLR_n(sclr1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, got);
    end
  endtask

  // Runs one frame on dut0 and checks captured data and every cycle's timing.
  task automatic run_frame(input string tag, input logic [31:0] h, input logic [7:0] l,
                           input logic [7:0] p, input logic [63:0] exp_frame,
                           input bit inject);
    logic [63:0] cap;
    int edges, busy_bad, pen_bad, done_bad, dones, overlap;
    logic prev;
    @(negedge clk);
    hexs = h; les = l; points = p; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    cap = '0; edges = 0; busy_bad = 0; pen_bad = 0; done_bad = 0;
    dones = 0; overlap = 0; prev = 1'b0;
    for (int c = 1; c <= 129 * D0 + 12; c++) begin
      @(negedge clk);
      if (sclk0 && !prev) begin
        cap = {cap[62:0], sdt0};
        edges++;
      end
      prev = sclk0;
      if (busy0 !== (c <= 129 * D0)) busy_bad++;
      if (spen0 !== (c >= 128 * D0 + 1 && c <= 129 * D0)) pen_bad++;
      if (done0 !== (c == 129 * D0 + 1)) done_bad++;
      if (done0) dones++;
      if (spen0 && sclk0) overlap++;
      if (inject && c == 50) begin hexs = 32'h0; les = 8'hFF; start0 = 1'b1; end
      if (inject && c == 51) start0 = 1'b0;
    end
    check({tag, "_frame"}, cap, exp_frame);
    check({tag, "_edges"}, 64'(edges), 64'd64);
    check({tag, "_busy_bad"}, 64'(busy_bad), 64'd0);
    check({tag, "_pen_bad"}, 64'(pen_bad), 64'd0);
    check({tag, "_done_bad"}, 64'(done_bad), 64'd0);
    check({tag, "_dones"}, 64'(dones), 64'd1);
    check({tag, "_pen_clk_overlap"}, 64'(overlap), 64'd0);
  endtask

  task automatic mid_reset;
    int pens, dones;
    @(negedge clk);
    hexs = 32'h01234567; les = '0; points = '0; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    for (int c = 1; c <= 100; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {58'd0, busy0, done0, sclk0, sdt0, spen0, sclr0}, 64'd0);
    rst = 1'b0;
    pens = 0; dones = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (spen0) pens++;
      if (done0) dones++;
    end
    check("midrst_no_pen", 64'(pens), 64'd0);
    check("midrst_no_done", 64'(dones), 64'd0);
    check("midrst_idle_busy", {63'd0, busy0}, 64'd0);
  endtask

  task automatic back_to_back;
    int edges, ndone, last_done, overlap;
    logic prev, expect_busy;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    edges = 0; ndone = 0; last_done = 0; overlap = 0;
    prev = 1'b0; expect_busy = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (sclk1 && !prev) edges++;
      prev = sclk1;
      if (spen1 && sclk1) overlap++;
      if (expect_busy) begin
        check("b2b_busy_after_done", {63'd0, busy1}, 64'd1);
        expect_busy = 1'b0;
      end
      if (done1) begin
        ndone++;
        check("b2b_edges", 64'(edges), 64'd64);
        check("b2b_done_gap", 64'(c - last_done), 64'd130);
        edges = 0;
        last_done = c;
        expect_busy = 1'b1;
      end
    end
    start1 = 1'b0;
    check("b2b_done_count", 64'(ndone), 64'd3);
    check("b2b_pen_clk_overlap", 64'(overlap), 64'd0);
    repeat (200) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {58'd0, busy0, done0, sclk0, sdt0, spen0, sclr0}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_release", {62'd0, sclr0, busy0}, 64'd2);

    run_frame("basic", 32'h01234567, 8'h00, 8'h00, 64'hC0F9A4B0999282F8, 1'b0);
    run_frame("blank_point", 32'hFFFF_FFFF, 8'h0F, 8'h80, 64'h0E8E8E8EFFFFFFFF, 1'b0);
    run_frame("freeze", 32'h89ABCDEF, 8'h00, 8'h01, 64'h80908883C6A1860E, 1'b1);
    mid_reset();
    run_frame("after_rst", 32'h01234567, 8'h00, 8'h00, 64'hC0F9A4B0999282F8, 1'b0);
    back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
